// File: rtl/spram_bw_if.sv
// spram_bw_if: access-port bundle of the single-port byte-write RAM.
//   ena            - access enable (read and/or write)
//   wea            - per-lane write enable, one bit per byte lane
//   addra          - word address
//   dina           - write data
//   douta          - read data (driven by the RAM)
//   regcea         - clock enable of the final output register
//   sleep          - suppresses all array accesses
//   injectsbiterra - ECC inject, carried but unused
//   injectdbiterra - ECC inject, carried but unused
// The master modport drives requests; the slave modport is the RAM side.
interface spram_bw_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 4
);
  logic                  ena;
  logic [NUM_LANES-1:0]  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] douta;
  logic                  regcea;
  logic                  sleep;
  logic                  injectsbiterra;
  logic                  injectdbiterra;

  modport master (
    output ena, wea, addra, dina, regcea, sleep, injectsbiterra, injectdbiterra,
    input  douta
  );

  modport slave (
    input  ena, wea, addra, dina, regcea, sleep, injectsbiterra, injectdbiterra,
    output douta
  );
endinterface

// File: rtl/spram_bw.sv
// spram_bw: synchronous single-port block RAM, read-first, per-byte write
// enables and a configurable read pipeline.
//   clk  - sole clock, rising edge
//   nrst - synchronous active-low reset; clears the read pipeline only,
//          never the array contents
//   bus  - spram_bw_if slave modport carrying ena/wea/addra/dina/douta/
//          regcea/sleep and the (ignored) ECC inject pins
// The address is a word index; only its low clog2(depth) bits select the
// word, so addresses wrap modulo depth.
module spram_bw #(
  parameter int ADDR_WIDTH_A       = 30,
  parameter int MEMORY_SIZE        = 1048576,
  parameter int WRITE_DATA_WIDTH_A = 32,
  parameter int READ_DATA_WIDTH_A  = 32,
  parameter int BYTE_WRITE_WIDTH_A = 8,
  parameter int READ_LATENCY_A     = 1
) (
  input logic       clk,
  input logic       nrst,
  spram_bw_if.slave bus
);

  localparam int DEPTH     = MEMORY_SIZE / WRITE_DATA_WIDTH_A;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NUM_LANES = WRITE_DATA_WIDTH_A / BYTE_WRITE_WIDTH_A;
  localparam int BW        = BYTE_WRITE_WIDTH_A;

  logic                          access;
  logic [IDX_W-1:0]              idx;
  logic [READ_DATA_WIDTH_A-1:0]  rd_word;

  // Sleep gates both reads and writes of the array; the pipeline behind it
  // keeps running so in-flight data still drains.
  assign access = bus.ena & ~bus.sleep;
  assign idx    = bus.addra[IDX_W-1:0];

  // Each byte lane is its own narrow array so the write enable maps directly
  // onto a block-RAM byte-write port. The read register sits in the same
  // process as the write: with non-blocking updates it captures the
  // pre-write word, giving read-first behaviour on a same-address write.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [BW-1:0] mem_q [DEPTH] = '{default: '0};
      logic [BW-1:0] rd_q;

      always_ff @(posedge clk) begin
        // Array writes are independent of nrst on purpose.
        if (access && bus.wea[gi]) begin
          mem_q[idx] <= bus.dina[gi*BW +: BW];
        end
        if (!nrst) begin
          rd_q <= '0;
        end else if (access) begin
          rd_q <= mem_q[idx];
        end
      end

      assign rd_word[gi*BW +: BW] = rd_q;
    end
  endgenerate

  // Output pipeline. Stage 1 is the lane read registers above. For a
  // latency above one, middle stages shift every cycle and the last stage
  // is gated by regcea.
  generate
    if (READ_LATENCY_A <= 1) begin : g_lat1
      assign bus.douta = rd_word;
    end else begin : g_pipe
      for (genvar gi = 2; gi <= READ_LATENCY_A; gi++) begin : g_stage
        logic [READ_DATA_WIDTH_A-1:0] stage_q;
        logic [READ_DATA_WIDTH_A-1:0] stage_d;

        if (gi == 2) begin : g_src_first
          assign stage_d = rd_word;
        end else begin : g_src_prev
          assign stage_d = g_stage[gi-1].stage_q;
        end

        if (gi == READ_LATENCY_A) begin : g_out
          always_ff @(posedge clk) begin
            if (!nrst) begin
              stage_q <= '0;
            end else if (bus.regcea) begin
              stage_q <= stage_d;
            end
          end
        end else begin : g_mid
          always_ff @(posedge clk) begin
            if (!nrst) begin
              stage_q <= '0;
            end else begin
              stage_q <= stage_d;
            end
          end
        end
      end

      assign bus.douta = g_stage[READ_LATENCY_A].stage_q;
    end
  endgenerate

  // ECC injects have no function here; regcea is unused at latency one and
  // the upper address bits are ignored so addresses wrap.
  logic unused_ok;
  assign unused_ok = ^{bus.injectsbiterra, bus.injectdbiterra, bus.regcea, bus.addra};

endmodule

// File: tb/tb_spram_bw.sv
module tb_spram_bw;

  localparam int AW    = 30;
  localparam int DW    = 32;
  localparam int NL    = 4;
  localparam int DEPTH = 32768;

  logic          clk = 1'b0;
  logic          nrst;
  logic          ena;
  logic [NL-1:0] wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          regcea;
  logic          sleep;
  logic          injs;
  logic          injd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spram_bw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LANES(NL)) bus1 ();
  spram_bw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LANES(NL)) bus3 ();

  assign bus1.ena = ena;            assign bus3.ena = ena;
  assign bus1.wea = wea;            assign bus3.wea = wea;
  assign bus1.addra = addra;        assign bus3.addra = addra;
  assign bus1.dina = dina;          assign bus3.dina = dina;
  assign bus1.regcea = regcea;      assign bus3.regcea = regcea;
  assign bus1.sleep = sleep;        assign bus3.sleep = sleep;
  assign bus1.injectsbiterra = injs; assign bus3.injectsbiterra = injs;
  assign bus1.injectdbiterra = injd; assign bus3.injectdbiterra = injd;

  spram_bw #(.READ_LATENCY_A(1)) u_dut1 (.clk(clk), .nrst(nrst), .bus(bus1.slave));
  spram_bw #(.READ_LATENCY_A(3)) u_dut3 (.clk(clk), .nrst(nrst), .bus(bus3.slave));

  // Behavioural model: a word array plus a history of the word captured by
  // each edge; the latency-3 output is looked up two edges back in history.
  logic [DW-1:0] mmem [DEPTH];
  logic [DW-1:0] exp1 = '0;
  logic [DW-1:0] exp3 = '0;
  logic [DW-1:0] s1_p1 = '0;   // captured word after the previous edge
  logic [DW-1:0] s1_p2 = '0;   // captured word two edges ago
  logic          rst_p1 = 1'b0;
  logic          chk_en = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
  end

  always @(posedge clk) begin
    logic          acc;
    logic [14:0]   ix;
    logic [DW-1:0] rd;
    logic [DW-1:0] s1_new;
    acc = ena && !sleep;
    ix  = addra[14:0];
    rd  = mmem[ix];
    if (acc) begin
      for (int l = 0; l < NL; l++)
        if (wea[l]) mmem[ix][l*8 +: 8] = dina[l*8 +: 8];
    end
    if (!nrst)    s1_new = '0;
    else if (acc) s1_new = rd;
    else          s1_new = s1_p1;
    if (!nrst)       exp3 = '0;
    else if (regcea) exp3 = rst_p1 ? '0 : s1_p2;
    exp1   = s1_new;
    s1_p2  = s1_p1;
    s1_p1  = s1_new;
    rst_p1 = !nrst;
    chk_en = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (bus1.douta !== exp1) begin
        failures++;
        $display("FAIL model_lat1 t=%0t douta=%08h expected=%08h", $time, bus1.douta, exp1);
      end
      checks++;
      if (bus3.douta !== exp3) begin
        failures++;
        $display("FAIL model_lat3 t=%0t douta=%08h expected=%08h", $time, bus3.douta, exp3);
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s douta=%08h expected=%08h", name, act, expv);
    end else begin
      $display("ok   %s douta=%08h", name, act);
    end
  endtask

  // One cycle: drive at the falling edge, return at the next falling edge,
  // so outputs then reflect the rising edge that consumed these inputs.
  task automatic cyc(input logic en, input logic [NL-1:0] we, input logic [AW-1:0] ad,
                     input logic [DW-1:0] d, input logic rce = 1'b1,
                     input logic slp = 1'b0, input logic rn = 1'b1);
    ena = en; wea = we; addra = ad; dina = d; regcea = rce; sleep = slp; nrst = rn;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; ena = 1'b0; wea = '0; addra = '0; dina = '0;
    regcea = 1'b1; sleep = 1'b0; injs = 1'b0; injd = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_lat1", bus1.douta, 32'h0);
    check("reset_lat3", bus3.douta, 32'h0);

    // Basic write/read, byte lanes, and latency-3 arrival
    cyc(1, 4'hF, 30'd5, 32'hDEADBEEF);
    cyc(1, 4'h0, 30'd5, 32'h0);                     // read at edge k
    check("basic_read", bus1.douta, 32'hDEADBEEF);
    cyc(1, 4'b0101, 30'd5, 32'h11223344);
    check("lane_write_readfirst", bus1.douta, 32'hDEADBEEF);
    cyc(1, 4'h0, 30'd5, 32'h0);                     // edge k+2
    check("lane_merge", bus1.douta, 32'hDE22BE44);
    check("lat3_arrival", bus3.douta, 32'hDEADBEEF);

    // Read-first collision
    cyc(1, 4'hF, 30'd7, 32'hAAAA5555);
    cyc(1, 4'hF, 30'd7, 32'h12345678);
    check("collision_old", bus1.douta, 32'hAAAA5555);
    cyc(1, 4'h0, 30'd7, 32'h0);
    check("collision_new", bus1.douta, 32'h12345678);

    // regcea gating on the latency-3 output
    cyc(0, 4'h0, 30'd0, 32'h0);
    cyc(0, 4'h0, 30'd0, 32'h0);
    check("lat3_settle", bus3.douta, 32'h12345678);
    cyc(1, 4'h0, 30'd5, 32'h0);
    cyc(0, 4'h0, 30'd0, 32'h0);
    cyc(0, 4'h0, 30'd0, 32'h0, 1'b0);
    check("regcea_hold1", bus3.douta, 32'h12345678);
    cyc(0, 4'h0, 30'd0, 32'h0, 1'b0);
    check("regcea_hold2", bus3.douta, 32'h12345678);
    cyc(0, 4'h0, 30'd0, 32'h0, 1'b1);
    check("regcea_release", bus3.douta, 32'hDE22BE44);

    // Reset while a read is in flight
    cyc(1, 4'h0, 30'd7, 32'h0);
    cyc(0, 4'h0, 30'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("midreset_lat1", bus1.douta, 32'h0);
    check("midreset_lat3", bus3.douta, 32'h0);
    cyc(0, 4'h0, 30'd0, 32'h0);
    cyc(0, 4'h0, 30'd0, 32'h0);
    check("midreset_drained", bus3.douta, 32'h0);
    cyc(1, 4'h0, 30'd7, 32'h0);
    check("array_intact", bus1.douta, 32'h12345678);

    // Sleep suppresses writes
    cyc(1, 4'hF, 30'd7, 32'hFFFFFFFF, 1'b1, 1'b1);
    check("sleep_hold", bus1.douta, 32'h12345678);
    cyc(1, 4'h0, 30'd7, 32'h0);
    check("sleep_nowrite", bus1.douta, 32'h12345678);

    // Address wrap with ECC injects toggling
    injs = 1'b1;
    cyc(1, 4'hF, 30'd32771, 32'hCAFEF00D);
    injd = 1'b1;
    cyc(1, 4'h0, 30'd3, 32'h0);
    check("addr_wrap", bus1.douta, 32'hCAFEF00D);
    injs = 1'b0; injd = 1'b0;

    // Randomised phase checked every cycle by the model compare process
    for (int n = 0; n < 2000; n++) begin
      logic          r_en;
      logic [NL-1:0] r_we;
      logic [AW-1:0] r_ad;
      r_en = ($urandom_range(0, 9) < 8);
      r_we = ($urandom_range(0, 1) == 0) ? 4'h0 : NL'($urandom_range(1, 15));
      r_ad = (AW'($urandom()) & 30'h3FFF8000) | AW'($urandom_range(0, 15));
      injs = 1'($urandom_range(0, 1));
      injd = 1'($urandom_range(0, 1));
      cyc(r_en, r_we, r_ad, $urandom(),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 29) != 0));
      if (n % 250 == 0)
        $display("rand n=%0d addr=%08h douta1=%08h douta3=%08h", n, r_ad, bus1.douta, bus3.douta);
    end

    cyc(0, 4'h0, 30'd0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
